// File: rtl/z3_slave_ctrl_if.sv
// Zorro III slave-side bus bundle: card pins, region configuration and back-end request lines.
interface z3_slave_ctrl_if #(
  parameter int unsigned NUM_REGIONS = 2,
  parameter int unsigned MATCH_BITS  = 4
);
  logic [25:0]                       A;
  logic [3:0]                        AD_HI;
  logic                              FCS_n;
  logic [3:0]                        DS_n;
  logic                              READ;
  logic                              DOE;
  logic                              BERR_n;
  logic                              MTCR_n;
  logic                              cfg_mode;
  logic [NUM_REGIONS*MATCH_BITS-1:0] base_addr;
  logic [NUM_REGIONS-1:0]            region_en;
  logic                              target_ack;

  logic                              cycle_start;
  logic [25:0]                       cycle_addr;
  logic                              cycle_rw;
  logic [3:0]                        cycle_be;
  logic [NUM_REGIONS-1:0]            region_hit;
  logic                              cfg_hit;
  logic                              SLAVE_n;
  logic                              DTACK_n;
  logic                              dtack_oe;
  logic                              MTACK_n;
  logic                              mtack_oe;
  logic                              BUFOE_n;
  logic                              BUFDIR;
  logic                              timeout;

  modport slave (
    input  A, AD_HI, FCS_n, DS_n, READ, DOE, BERR_n, MTCR_n,
           cfg_mode, base_addr, region_en, target_ack,
    output cycle_start, cycle_addr, cycle_rw, cycle_be, region_hit, cfg_hit,
           SLAVE_n, DTACK_n, dtack_oe, MTACK_n, mtack_oe, BUFOE_n, BUFDIR, timeout
  );

  modport master (
    output A, AD_HI, FCS_n, DS_n, READ, DOE, BERR_n, MTCR_n,
           cfg_mode, base_addr, region_en, target_ack,
    input  cycle_start, cycle_addr, cycle_rw, cycle_be, region_hit, cfg_hit,
           SLAVE_n, DTACK_n, dtack_oe, MTACK_n, mtack_oe, BUFOE_n, BUFDIR, timeout
  );
endinterface

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave cycle controller: strobe sync, address capture/decode, SLAVE/DTACK handshake.
// Optional multi-transfer support is enabled by defining MULTI_TRANSFER_EN.
module z3_slave_ctrl #(
  parameter int unsigned NUM_REGIONS = 2,
  parameter int unsigned MATCH_BITS  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           RST_n,
  z3_slave_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_DS,
    S_REQ,
    S_WAIT_ACK,
    S_ACK,
    S_NOMATCH,
    S_WAIT_END
`ifdef MULTI_TRANSFER_EN
    , S_MT_WAIT
`endif
  } state_t;

  state_t                         r_state;
  state_t                         w_next;

  logic [SYNC_STAGES-1:0]         r_fcs_sync;
  logic [SYNC_STAGES-1:0][3:0]    r_ds_sync;
  logic                           w_fcs_s;
  logic [3:0]                     w_ds_s;

  logic [25:0]                    r_addr;
  logic                           r_rw;
  logic [3:0]                     r_cycle_be;
  logic [NUM_REGIONS-1:0]         r_region_hit;
  logic                           r_cfg_hit;
  logic                           r_cycle_start;
  logic                           r_dtack_n;
  logic                           r_timeout;
  logic [CNT_W-1:0]               r_cnt;

  logic                           w_capture;
  logic                           w_berr;
  logic                           w_to;
  logic [7:0]                     w_top8;
  logic                           w_dec_cfg;
  logic [NUM_REGIONS-1:0]         w_dec_hit;
  logic                           w_found;
  logic                           w_any_hit;
  logic                           w_slave;
  logic                           w_buf_state;

  // Strobe synchronisers; bit 0 is the first stage
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_fcs_sync <= '1;
      r_ds_sync  <= '1;
    end else begin
      r_fcs_sync <= {r_fcs_sync[SYNC_STAGES-2:0], bus.FCS_n};
      r_ds_sync  <= {r_ds_sync[SYNC_STAGES-2:0], bus.DS_n};
    end
  end

  assign w_fcs_s   = r_fcs_sync[SYNC_STAGES-1];
  assign w_ds_s    = r_ds_sync[SYNC_STAGES-1];
  assign w_capture = (r_state == S_IDLE) && !r_fcs_sync[0];
  assign w_berr    = !bus.BERR_n;

`ifdef MULTI_TRANSFER_EN
  logic [SYNC_STAGES-1:0] r_mtcr_sync;
  logic                   r_mtcr_d;
  logic                   r_mt;
  logic                   w_mtcr_fall;

  // MTCR_n sync plus edge history; r_mt marks a multi-transfer full cycle
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_mtcr_sync <= '1;
      r_mtcr_d    <= 1'b1;
      r_mt        <= 1'b0;
    end else begin
      r_mtcr_sync <= {r_mtcr_sync[SYNC_STAGES-2:0], bus.MTCR_n};
      r_mtcr_d    <= r_mtcr_sync[SYNC_STAGES-1];
      if (w_capture) begin
        r_mt <= !bus.MTCR_n && !w_dec_cfg && (|w_dec_hit);
      end
    end
  end

  assign w_mtcr_fall  = r_mtcr_d && !r_mtcr_sync[SYNC_STAGES-1];
  assign bus.MTACK_n  = !(r_mt && (r_state != S_IDLE));
  assign bus.mtack_oe = r_mt && w_slave;
`else
  logic w_mtcr_unused;
  assign w_mtcr_unused = bus.MTCR_n;
  assign bus.MTACK_n   = 1'b1;
  assign bus.mtack_oe  = 1'b0;
`endif

  // Address decode on the live bus, registered at capture
  assign w_top8    = {bus.AD_HI, bus.A[25:22]};
  assign w_dec_cfg = bus.cfg_mode && (w_top8 == 8'hFF);

  always_comb begin
    w_dec_hit = '0;
    w_found   = 1'b0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      if (!w_found && bus.region_en[i] &&
          (w_top8[7 -: MATCH_BITS] == bus.base_addr[i*MATCH_BITS +: MATCH_BITS])) begin
        w_dec_hit[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
    if (w_dec_cfg) begin
      w_dec_hit = '0;
    end
  end

  assign w_any_hit = (|r_region_hit) || r_cfg_hit;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; bus error outranks every other exit from an active state
  always_comb begin
    w_next = r_state;
    w_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_berr)                                 w_next = S_WAIT_END;
        else if (w_any_hit)                         w_next = S_WAIT_DS;
        else                                        w_next = S_NOMATCH;
      end
      S_WAIT_DS: begin
        if (w_berr)                                 w_next = S_WAIT_END;
        else if (w_fcs_s)                           w_next = S_IDLE;
        else if (w_ds_s != 4'hF)                    w_next = S_REQ;
      end
      S_REQ: begin
        if (w_berr)                                 w_next = S_WAIT_END;
        else                                        w_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (w_berr)                                 w_next = S_WAIT_END;
        else if (w_fcs_s)                           w_next = S_IDLE;
        else if (bus.target_ack)                    w_next = S_ACK;
        else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_next = S_WAIT_END;
          w_to   = 1'b1;
        end
      end
      S_ACK: begin
        if (w_berr)                                 w_next = S_WAIT_END;
        else if (w_fcs_s)                           w_next = S_IDLE;
`ifdef MULTI_TRANSFER_EN
        else if (r_mt && (w_ds_s == 4'hF))          w_next = S_MT_WAIT;
`endif
      end
`ifdef MULTI_TRANSFER_EN
      S_MT_WAIT: begin
        if (w_berr)                                 w_next = S_WAIT_END;
        else if (w_fcs_s)                           w_next = S_IDLE;
        else if (w_mtcr_fall)                       w_next = S_WAIT_DS;
      end
`endif
      S_NOMATCH, S_WAIT_END: begin
        if (w_fcs_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture registers, request pulse, ack value and timeout counter
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_addr        <= '0;
      r_rw          <= 1'b1;
      r_cycle_be    <= '0;
      r_region_hit  <= '0;
      r_cfg_hit     <= 1'b0;
      r_cycle_start <= 1'b0;
      r_dtack_n     <= 1'b1;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_cycle_start <= (w_next == S_REQ);
      r_dtack_n     <= (w_next != S_ACK);
      r_timeout     <= w_to;
      if (w_next == S_REQ) begin
        r_cycle_be <= ~w_ds_s;
        r_cnt      <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT_ACK)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_addr       <= bus.A;
        r_rw         <= bus.READ;
        r_region_hit <= w_dec_hit;
        r_cfg_hit    <= w_dec_cfg;
      end
`ifdef MULTI_TRANSFER_EN
      if ((r_state == S_MT_WAIT) && (w_next == S_WAIT_DS)) begin
        r_addr[5:0] <= bus.A[5:0];
      end
`endif
    end
  end

  // SLAVE_n follows raw FCS_n so it releases the instant the master ends the cycle
  assign w_slave     = !bus.FCS_n && w_any_hit &&
                       !(r_state inside {S_IDLE, S_DECODE, S_NOMATCH});
  assign w_buf_state = r_state inside {S_WAIT_DS, S_REQ, S_WAIT_ACK, S_ACK};

  assign bus.SLAVE_n     = !w_slave;
  assign bus.dtack_oe    = w_slave;
  assign bus.DTACK_n     = r_dtack_n;
  assign bus.BUFOE_n     = !(w_buf_state && w_any_hit && bus.DOE && bus.BERR_n);
  assign bus.BUFDIR      = bus.READ;
  assign bus.cycle_start = r_cycle_start;
  assign bus.cycle_addr  = r_addr;
  assign bus.cycle_rw    = r_rw;
  assign bus.cycle_be    = r_cycle_be;
  assign bus.region_hit  = r_region_hit;
  assign bus.cfg_hit     = r_cfg_hit;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_z3_slave_ctrl.sv
// Bench for z3_slave_ctrl: directed and randomized full cycles checked against a decode/timing model.
module tb_z3_slave_ctrl;

  localparam int unsigned NR = 2;
  localparam int unsigned MB = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  z3_slave_ctrl_if #(.NUM_REGIONS(NR), .MATCH_BITS(MB)) bus ();

  z3_slave_ctrl #(
    .NUM_REGIONS(NR), .MATCH_BITS(MB), .SYNC_STAGES(2), .ACK_TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RST_n(rst_n), .bus(bus)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Reference decode: address as a 32-bit number, regions scanned high-to-low so the lowest index wins
  function automatic void model_decode(input logic [3:0] adhi, input logic [25:0] a, input logic cm,
                                       input logic [NR*MB-1:0] base, input logic [NR-1:0] en,
                                       output logic [NR-1:0] hit, output logic cfg);
    int unsigned addr, top, fld;
    addr = {adhi, a, 2'b00};
    top  = addr >> (32 - MB);
    cfg  = cm && ((addr >> 24) == 255);
    hit  = '0;
    if (!cfg) begin
      for (int i = NR - 1; i >= 0; i--) begin
        fld = (int'(base) >> (i * MB)) & ((1 << MB) - 1);
        if (en[i] && fld == top) hit = NR'(1) << i;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_cycle(input logic [3:0] adhi, input logic [25:0] a, input logic rd,
                             input logic [3:0] ds, input logic mtcr);
    bus.AD_HI  = adhi;
    bus.A      = a;
    bus.READ   = rd;
    bus.MTCR_n = mtcr;
    bus.DS_n   = ds;
    bus.FCS_n  = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit seen, output bit slave_lo);
    seen = 0;
    slave_lo = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (bus.SLAVE_n === 1'b0) slave_lo = 1;
      if (bus.cycle_start === 1'b1) seen = 1;
    end
  endtask

  task automatic end_cycle(output logic slave_after);
    bus.FCS_n  = 1'b1;
    bus.DS_n   = 4'hF;
    bus.MTCR_n = 1'b1;
    #1 slave_after = bus.SLAVE_n;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    bus.A = '0; bus.AD_HI = '0; bus.FCS_n = 1'b1; bus.DS_n = 4'hF; bus.READ = 1'b1;
    bus.DOE = 1'b1; bus.BERR_n = 1'b1; bus.MTCR_n = 1'b1; bus.cfg_mode = 1'b0;
    bus.base_addr = '0; bus.region_en = '0; bus.target_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({bus.cycle_start, bus.SLAVE_n, bus.DTACK_n, bus.dtack_oe, bus.MTACK_n, bus.mtack_oe,
         bus.BUFOE_n, bus.timeout} !== 8'b0110_1010) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 01101010", {bus.cycle_start, bus.SLAVE_n, bus.DTACK_n,
               bus.dtack_oe, bus.MTACK_n, bus.mtack_oe, bus.BUFOE_n, bus.timeout});
    end
    n_vec++;
    if ({bus.cycle_addr, bus.cycle_rw, bus.cycle_be, bus.region_hit, bus.cfg_hit} !== {26'h0, 1'b1, 4'h0, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h rw=%b be=%h hit=%b cfg=%b want 0/1/0/00/0",
               bus.cycle_addr, bus.cycle_rw, bus.cycle_be, bus.region_hit, bus.cfg_hit);
    end
    #3 rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_cfg();
    logic [25:0] a;
    bit seen, slo;
    int extra;
    logic srel;
    bus.cfg_mode = 1'b1; bus.base_addr = 8'hFF; bus.region_en = 2'b11; bus.DOE = 1'b1;
    a = 26'($urandom);
    a[25:22] = 4'hF;
    begin_cycle(4'hF, a, 1'b1, 4'h0, 1'b1);
    wait_start(12, seen, slo);
    n_vec++;
    if (!seen || !slo) begin
      n_err++; $display("FAIL cfg_start: got start=%0d slave_lo=%0d want 1/1", seen, slo);
    end
    n_vec++;
    if ({bus.cfg_hit, bus.region_hit, bus.cycle_addr, bus.cycle_rw, bus.cycle_be} !== {1'b1, 2'b00, a, 1'b1, 4'hF}) begin
      n_err++;
      $display("FAIL cfg_fields: got cfg=%b hit=%b addr=%h rw=%b be=%h want 1/00/%h/1/f",
               bus.cfg_hit, bus.region_hit, bus.cycle_addr, bus.cycle_rw, bus.cycle_be, a);
    end
    extra = 0;
    repeat (3) begin
      tick();
      if (bus.cycle_start !== 1'b0 || bus.DTACK_n !== 1'b1) extra++;
    end
    bus.target_ack = 1'b1;
    tick();
    bus.target_ack = 1'b0;
    n_vec++;
    if (bus.DTACK_n !== 1'b0 || bus.dtack_oe !== 1'b1) begin
      n_err++; $display("FAIL cfg_dtack: got DTACK_n=%b oe=%b want 0/1", bus.DTACK_n, bus.dtack_oe);
    end
    bus.DOE = 1'b0;
    #1;
    n_vec++;
    if (bus.BUFOE_n !== 1'b1) begin
      n_err++; $display("FAIL cfg_bufoe_doe0: got %b want 1", bus.BUFOE_n);
    end
    bus.DOE = 1'b1;
    #1;
    n_vec++;
    if (bus.BUFOE_n !== 1'b0 || bus.BUFDIR !== 1'b1) begin
      n_err++; $display("FAIL cfg_bufoe_doe1: got BUFOE_n=%b BUFDIR=%b want 0/1", bus.BUFOE_n, bus.BUFDIR);
    end
    repeat (3) begin
      tick();
      if (bus.cycle_start !== 1'b0 || bus.DTACK_n !== 1'b0) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL cfg_hold: got %0d bad cycles want 0", extra);
    end
    end_cycle(srel);
    n_vec++;
    if (srel !== 1'b1 || bus.DTACK_n !== 1'b1 || bus.dtack_oe !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_release: got SLAVE_n=%b DTACK_n=%b oe=%b want 1/1/0", srel, bus.DTACK_n, bus.dtack_oe);
    end
  endtask

  task automatic test_decode();
    logic [NR*MB-1:0] base;
    logic [NR-1:0] en, ehit;
    logic cm, ecfg, rd, srel;
    logic [3:0] adhi, ds;
    logic [25:0] a;
    bit seen, slo, exp_hit;
    int dly, early;
    for (int t = 0; t < 28; t++) begin
      a = 26'($urandom);
      rd = 1'($urandom);
      ds = 4'($urandom);
      if (ds == 4'hF) ds = 4'hE;
      dly = 1 + int'($urandom % 5);
      case (t)
        0: begin cm = 0; base = 8'h42; en = 2'b11; adhi = 4'h4; rd = 1'b0; end
        1: begin cm = 0; base = 8'h42; en = 2'b11; adhi = 4'h7; end
        2: begin cm = 0; base = 8'h22; en = 2'b11; adhi = 4'h2; end
        3: begin cm = 0; base = 8'h22; en = 2'b10; adhi = 4'h2; end
        default: begin
          cm = 1'($urandom); base = 8'($urandom); en = 2'($urandom);
          adhi = ($urandom % 2 == 0) ? 4'(base >> (($urandom % NR) * MB)) : 4'($urandom);
          if (cm && $urandom % 2 == 0) begin adhi = 4'hF; a[25:22] = 4'hF; end
        end
      endcase
      bus.cfg_mode = cm; bus.base_addr = base; bus.region_en = en;
      model_decode(adhi, a, cm, base, en, ehit, ecfg);
      exp_hit = (ehit != 0) || ecfg;
      begin_cycle(adhi, a, rd, ds, 1'b1);
      wait_start(12, seen, slo);
      n_vec++;
      if (seen != exp_hit || slo != exp_hit) begin
        n_err++;
        $display("FAIL dec_start[%0d]: got start=%0d slave_lo=%0d want %0d", t, seen, slo, exp_hit);
      end
      if (seen && exp_hit) begin
        n_vec++;
        if ({bus.cfg_hit, bus.region_hit, bus.cycle_addr, bus.cycle_rw, bus.cycle_be} !== {ecfg, ehit, a, rd, ~ds}) begin
          n_err++;
          $display("FAIL dec_fields[%0d]: got cfg=%b hit=%b addr=%h rw=%b be=%h want %b/%b/%h/%b/%h",
                   t, bus.cfg_hit, bus.region_hit, bus.cycle_addr, bus.cycle_rw, bus.cycle_be,
                   ecfg, ehit, a, rd, ~ds);
        end
        early = 0;
        repeat (dly) begin
          tick();
          if (bus.DTACK_n !== 1'b1) early++;
        end
        bus.target_ack = 1'b1;
        tick();
        bus.target_ack = 1'b0;
        n_vec++;
        if (early != 0 || bus.DTACK_n !== 1'b0) begin
          n_err++;
          $display("FAIL dec_dtack[%0d]: got early=%0d DTACK_n=%b want 0/0", t, early, bus.DTACK_n);
        end
      end
      end_cycle(srel);
      n_vec++;
      if (srel !== 1'b1 || bus.DTACK_n !== 1'b1) begin
        n_err++; $display("FAIL dec_end[%0d]: got SLAVE_n=%b DTACK_n=%b want 1/1", t, srel, bus.DTACK_n);
      end
    end
  endtask

  task automatic test_timeout();
    bit seen, slo;
    int first, pulses, dt;
    logic srel;
    bus.cfg_mode = 1'b0; bus.base_addr = 8'h42; bus.region_en = 2'b11;
    begin_cycle(4'h2, 26'($urandom), 1'b1, 4'h0, 1'b1);
    wait_start(12, seen, slo);
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL to_start: got 0 want 1");
    end
    first = -1; pulses = 0; dt = 0;
    for (int j = 1; j <= int'(TO) + 4; j++) begin
      tick();
      if (bus.timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = j;
      end
      if (bus.DTACK_n !== 1'b1) dt++;
    end
    n_vec++;
    if (first != int'(TO) || pulses != 1) begin
      n_err++; $display("FAIL to_pulse: got at=%0d count=%0d want %0d/1", first, pulses, TO);
    end
    n_vec++;
    if (dt != 0) begin
      n_err++; $display("FAIL to_no_dtack: got %0d low cycles want 0", dt);
    end
    end_cycle(srel);
    n_vec++;
    if (srel !== 1'b1 || bus.dtack_oe !== 1'b0 || bus.SLAVE_n !== 1'b1) begin
      n_err++; $display("FAIL to_end: got SLAVE_n=%b oe=%b want 1/0", srel, bus.dtack_oe);
    end
  endtask

  task automatic test_berr();
    bit seen, slo;
    int bad;
    logic srel;
    bus.cfg_mode = 1'b0; bus.base_addr = 8'h42; bus.region_en = 2'b11; bus.DOE = 1'b1;
    begin_cycle(4'h4, 26'($urandom), 1'b0, 4'h3, 1'b1);
    wait_start(12, seen, slo);
    tick();
    n_vec++;
    if (!seen || bus.BUFOE_n !== 1'b0) begin
      n_err++; $display("FAIL berr_pre: got start=%0d BUFOE_n=%b want 1/0", seen, bus.BUFOE_n);
    end
    bus.BERR_n = 1'b0;
    tick();
    n_vec++;
    if (bus.BUFOE_n !== 1'b1) begin
      n_err++; $display("FAIL berr_bufoe: got %b want 1", bus.BUFOE_n);
    end
    bus.target_ack = 1'b1;
    tick();
    bus.target_ack = 1'b0;
    bus.BERR_n = 1'b1;
    bad = 0;
    repeat (4) begin
      tick();
      if (bus.DTACK_n !== 1'b1 || bus.cycle_start !== 1'b0 || bus.BUFOE_n !== 1'b1) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL berr_abort: got %0d bad cycles want 0", bad);
    end
    end_cycle(srel);
  endtask

  task automatic test_abort();
    bit seen, slo;
    logic srel;
    bus.cfg_mode = 1'b0; bus.base_addr = 8'h42; bus.region_en = 2'b11;
    begin_cycle(4'h2, 26'($urandom), 1'b1, 4'hF, 1'b1);
    wait_start(8, seen, slo);
    n_vec++;
    if (seen || !slo) begin
      n_err++; $display("FAIL abort_wait: got start=%0d slave_lo=%0d want 0/1", seen, slo);
    end
    end_cycle(srel);
    n_vec++;
    if (srel !== 1'b1 || bus.DTACK_n !== 1'b1) begin
      n_err++; $display("FAIL abort_end: got SLAVE_n=%b DTACK_n=%b want 1/1", srel, bus.DTACK_n);
    end
    begin_cycle(4'h4, 26'($urandom), 1'b1, 4'h0, 1'b1);
    wait_start(12, seen, slo);
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL abort_next: got start=0 want 1");
    end
    end_cycle(srel);
  endtask

  task automatic test_reset_mid();
    bit seen, slo;
    bus.cfg_mode = 1'b0; bus.base_addr = 8'h42; bus.region_en = 2'b11;
    begin_cycle(4'h4, 26'($urandom), 1'b0, 4'h0, 1'b1);
    wait_start(12, seen, slo);
    tick();
    bus.target_ack = 1'b1;
    tick();
    bus.target_ack = 1'b0;
    n_vec++;
    if (bus.DTACK_n !== 1'b0 || bus.SLAVE_n !== 1'b0) begin
      n_err++; $display("FAIL rstmid_pre: got DTACK_n=%b SLAVE_n=%b want 0/0", bus.DTACK_n, bus.SLAVE_n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.cycle_start, bus.SLAVE_n, bus.DTACK_n, bus.dtack_oe, bus.MTACK_n, bus.mtack_oe,
         bus.BUFOE_n, bus.timeout} !== 8'b0110_1010) begin
      n_err++;
      $display("FAIL rstmid_ctl: got %b want 01101010", {bus.cycle_start, bus.SLAVE_n, bus.DTACK_n,
               bus.dtack_oe, bus.MTACK_n, bus.mtack_oe, bus.BUFOE_n, bus.timeout});
    end
    n_vec++;
    if ({bus.cycle_addr, bus.cycle_rw, bus.cycle_be, bus.region_hit, bus.cfg_hit} !== {26'h0, 1'b1, 4'h0, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_data: got addr=%h rw=%b be=%h hit=%b cfg=%b want 0/1/0/00/0",
               bus.cycle_addr, bus.cycle_rw, bus.cycle_be, bus.region_hit, bus.cfg_hit);
    end
    bus.FCS_n = 1'b1;
    bus.DS_n = 4'hF;
    #2 rst_n = 1'b1;
    repeat (3) tick();
  endtask

`ifdef MULTI_TRANSFER_EN
  task automatic test_multi_transfer();
    logic [25:0] a;
    logic [3:0] ds;
    bit seen, slo;
    int starts;
    logic srel;
    bus.cfg_mode = 1'b0; bus.base_addr = 8'h42; bus.region_en = 2'b11;
    a = 26'($urandom);
    a[5:0] = 6'd0;
    starts = 0;
    begin_cycle(4'h2, a, 1'b1, 4'h0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      ds = 4'($urandom);
      if (ds == 4'hF) ds = 4'h0;
      if (p > 0) begin
        bus.A = {~a[25:6], 6'(p)};
        bus.DS_n = ds;
        bus.MTCR_n = 1'b0;
      end
      wait_start(12, seen, slo);
      if (seen) starts++;
      n_vec++;
      if (bus.cycle_addr !== {a[25:6], 6'(p)} || bus.MTACK_n !== 1'b0 || bus.mtack_oe !== 1'b1) begin
        n_err++;
        $display("FAIL mt_phase[%0d]: got addr=%h MTACK_n=%b oe=%b want %h/0/1",
                 p, bus.cycle_addr, bus.MTACK_n, bus.mtack_oe, {a[25:6], 6'(p)});
      end
      tick();
      bus.target_ack = 1'b1;
      tick();
      bus.target_ack = 1'b0;
      n_vec++;
      if (bus.DTACK_n !== 1'b0) begin
        n_err++; $display("FAIL mt_dtack[%0d]: got %b want 0", p, bus.DTACK_n);
      end
      bus.DS_n = 4'hF;
      bus.MTCR_n = 1'b1;
      repeat (4) tick();
      n_vec++;
      if (bus.DTACK_n !== 1'b1 || bus.MTACK_n !== 1'b0 || bus.SLAVE_n !== 1'b0) begin
        n_err++;
        $display("FAIL mt_wait[%0d]: got DTACK_n=%b MTACK_n=%b SLAVE_n=%b want 1/0/0",
                 p, bus.DTACK_n, bus.MTACK_n, bus.SLAVE_n);
      end
    end
    n_vec++;
    if (starts != 3) begin
      n_err++; $display("FAIL mt_starts: got %0d want 3", starts);
    end
    end_cycle(srel);
    n_vec++;
    if (bus.MTACK_n !== 1'b1 || bus.mtack_oe !== 1'b0) begin
      n_err++; $display("FAIL mt_end: got MTACK_n=%b oe=%b want 1/0", bus.MTACK_n, bus.mtack_oe);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cfg();
    test_decode();
    test_timeout();
    test_berr();
    test_abort();
    test_reset_mid();
`ifdef MULTI_TRANSFER_EN
    test_multi_transfer();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
